// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the configurable UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the state encoding.
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICKS  = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversample tick generator; clr holds the divider at zero.
module uart_baud_gen
  import uart_rx_pkg::*;
#(
  parameter int unsigned pBAUD_RATE    = 9600,
  parameter int unsigned pSYS_CLK_FREQ = 100000000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV = baud_div(pSYS_CLK_FREQ, pBAUD_RATE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with valid/ready output and error flags.
// Define UART_RX_PARITY_EN to receive and check a parity bit.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int unsigned pBAUD_RATE    = 9600,
  parameter int unsigned pSYS_CLK_FREQ = 100000000,
  parameter int unsigned pDATA_BITS    = 8,
  parameter int unsigned pSTOP_BITS    = 1,
  parameter int unsigned pPARITY_ODD   = 0
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [pDATA_BITS-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = 4;

  if (pDATA_BITS < 5 || pDATA_BITS > 9 || pSTOP_BITS < 1 || pSTOP_BITS > 2 || pPARITY_ODD > 1)
  begin : g_param_err
    $error("uart_rx_cfg: illegal parameter value");
  end

  uart_rx_state_t  state;
  logic            rx_meta, rx_s;
  logic            tick;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [pDATA_BITS-1:0] shreg;
  logic            ferr_acc;
  logic            perr_acc;
  logic            bit_end_c;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_gen #(
    .pBAUD_RATE    (pBAUD_RATE),
    .pSYS_CLK_FREQ (pSYS_CLK_FREQ)
  ) u_baud_gen (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr     (state == IDLE),
    .tick    (tick)
  );

  assign bit_end_c = tick && (tick_cnt == TW'(OVERSAMPLE - 1));

  // Receive FSM plus output holding register and handshake.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      ferr_acc    <= 1'b0;
      perr_acc    <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          ferr_acc <= 1'b0;
          perr_acc <= 1'b0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: if (tick) begin
          if (tick_cnt == TW'(MID_TICKS - 1)) begin
            tick_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

        DATA: if (tick) begin
          if (bit_end_c) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[pDATA_BITS-1:1]};
            if (bit_cnt == BW'(pDATA_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          if (bit_end_c) begin
            tick_cnt <= '0;
            perr_acc <= (^shreg) ^ rx_s ^ 1'(pPARITY_ODD);
            state    <= STOP;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
`endif

        STOP: if (tick) begin
          if (bit_end_c) begin
            tick_cnt <= '0;
            if (!rx_s) ferr_acc <= 1'b1;
            if (bit_cnt == BW'(pSTOP_BITS - 1)) begin
              // Frame complete: present it unless an unconsumed frame blocks it.
              bit_cnt <= '0;
              state   <= rx_s ? IDLE : WAIT_IDLE;
              busy    <= !rx_s;
              if (!data_valid || data_ready) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                frame_err  <= ferr_acc | !rx_s;
                parity_err <= perr_acc;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

        WAIT_IDLE: if (rx_s) begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter pBAUD_RATE, default 9600, meaning the line bit rate in bits/s.
REQ-002 SHALL have parameter pSYS_CLK_FREQ, default 100000000, meaning the sys_clk frequency in Hz.
REQ-003 SHALL have parameter pDATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter pSTOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have parameter pPARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity; it has effect only with UART_RX_PARITY_EN defined.
REQ-006 SHALL have port sys_clk, input, 1 bit: the single system clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port data_out, output, pDATA_BITS bits: received word, LSB first on the line.
REQ-010 SHALL have port data_valid, output, 1 bit: data_out and the error flags hold an unconsumed frame.
REQ-011 SHALL have port data_ready, input, 1 bit: consumer accepts the frame.
REQ-012 SHALL have port frame_err, output, 1 bit: the presented frame had a stop bit sampled low.
REQ-013 SHALL have port parity_err, output, 1 bit: the presented frame failed the parity check.
REQ-014 SHALL have port overrun_err, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer to give rx_s; the synchronizer flops reset to 1.
REQ-017 SHALL generate a 16x oversample tick: a one-cycle pulse every DIV = round(pSYS_CLK_FREQ/(16*pBAUD_RATE)) clocks (651 at the defaults); the divider counter SHALL be cleared in IDLE.
REQ-018 SHALL use the FSM states IDLE, START, DATA, PARITY, STOP, and WAIT_IDLE.
REQ-019 In IDLE, the FSM SHALL move to START on the first clock where rx_s = 0.
REQ-020 In START, the FSM SHALL re-sample rx_s after 8 ticks (mid-bit); a 1 is a false start and SHALL return the FSM to IDLE with no output; a 0 SHALL move the FSM to DATA.
REQ-021 In DATA, the FSM SHALL sample each bit every 16 ticks, shifting it in LSB first, for pDATA_BITS bits.
REQ-022 After the last data bit, the FSM SHALL go to PARITY (macro defined) or STOP (macro undefined).
REQ-023 In PARITY, the FSM SHALL sample 16 ticks later and compute parity_err = (XOR of the data bits, XOR the parity bit, XOR pPARITY_ODD) != 0.
REQ-024 In STOP, the FSM SHALL sample pSTOP_BITS stop bits 16 ticks apart; any 0 sampled SHALL set the frame's frame_err.
REQ-025 Completion SHALL occur on the final stop-bit sample; on the next clock the FSM SHALL return to IDLE, or to WAIT_IDLE if the last stop sample was 0.
REQ-026 WAIT_IDLE (break condition) SHALL hold until rx_s = 1 and then go to IDLE.
REQ-027 Completion latency: data_valid SHALL rise exactly 1 sys_clk after the final stop-bit sample.
REQ-028 Output handshake: a frame SHALL transfer on a cycle with data_valid & data_ready, and data_valid SHALL fall on the next clock unless a new frame completes on that same cycle, in which case the new frame SHALL load and data_valid SHALL stay high.
REQ-029 While data_valid is high, data_out, frame_err and parity_err SHALL remain stable.
REQ-030 If a frame completes while data_valid = 1 and data_ready = 0, the new frame SHALL be discarded, the old frame kept, and overrun_err SHALL pulse for 1 cycle.
REQ-031 Frames with errors SHALL still be presented, with their flags set.

Reset
REQ-032 rst SHALL asynchronously force: FSM to IDLE; divider, tick and bit counters to 0; shift register to 0; data_out = 0; data_valid = 0; frame_err = 0; parity_err = 0; overrun_err = 0; busy = 0.
REQ-033 Reset mid-frame SHALL abandon the frame, and that frame SHALL never be presented.
REQ-034 After reset, the block SHALL require rx_s = 0 in IDLE before starting a new frame.

Configuration
REQ-035 With macro UART_RX_PARITY_EN defined, the PARITY state and its check SHALL be compiled in.
REQ-036 With UART_RX_PARITY_EN undefined, the PARITY state SHALL be absent, the frame has no parity bit, and parity_err SHALL be tied to 0.

Structure
REQ-037 Package uart_rx_pkg SHALL hold the state enum type uart_rx_state_t and the constant OVERSAMPLE = 16.
REQ-038 The tick divider SHALL be the sub-module uart_baud_gen, with parameters pBAUD_RATE and pSYS_CLK_FREQ, inputs sys_clk, rst and clr, and output tick.

Verification
REQ-039 Defaults, no parity; send 0x59 LSB first at a 104160 ns bit period with data_ready = 1 -> data_out = 8'h59, data_valid high for 1 cycle, frame_err = 0.
REQ-040 rx low for 30 us then high (glitch shorter than half a bit) -> FSM returns to IDLE, data_valid never rises.
REQ-041 Send 0xA5 with the stop bit driven 0 and rx held low 3 bit times -> data_out = 8'hA5, frame_err = 1, FSM in WAIT_IDLE until rx returns high.
REQ-042 UART_RX_PARITY_EN defined, pPARITY_ODD = 0; send 0x07 with parity bit 1 then 0x07 with parity bit 0 -> parity_err = 0 on the first frame, 1 on the second.
REQ-043 data_ready = 0; send 0x11 then 0x22 -> data_out stays 8'h11, overrun_err pulses once at the second completion.
REQ-044 pDATA_BITS = 5, pSTOP_BITS = 2; send 5'h1B -> data_out = 5'h1B; assert rst during bit 3 of the next frame -> no data_valid, all outputs 0.
